algoritmo_param: RTL

Parametrised elevator dispatch controller for an N-floor car. It latches hall calls (up/down) and cab calls, and runs a collective-scan algorithm: keep the current direction while calls remain ahead, otherwise reverse. It tracks the car floor from floor-passing pulses and holds the door open for a programmable time. It sits between the button/sensor front end and the motor/door drivers, and replaces the fixed 4-floor dispatcher.

---
 rtl/algoritmo_param.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/algoritmo_param.sv
// Collective-scan elevator dispatcher for a PISOS-floor car: latches hall/cab calls,
// tracks the floor from passing pulses and times the door.
module algoritmo_param #(
  parameter int unsigned PISOS    = 4,
  parameter int unsigned W        = $clog2(PISOS),
  parameter int unsigned T_PUERTA = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PISOS-1:0] llamada_sube,
  input  logic [PISOS-1:0] llamada_baja,
  input  logic [PISOS-1:0] llamada_cabina,
  input  logic             cambio_piso,
  output logic [PISOS-1:0] pend_sube,
  output logic [PISOS-1:0] pend_baja,
  output logic [PISOS-1:0] pend_cabina,
  output logic [W-1:0]     piso,
  output logic             moviendo,
  output logic             subiendo,
  output logic             puerta_abierta
);

  localparam int unsigned TW = (T_PUERTA > 1) ? $clog2(T_PUERTA) : 1;
  localparam logic [TW-1:0] Carga = TW'(T_PUERTA - 1);
  localparam logic [W-1:0] Tope = W'(PISOS - 1);
  localparam logic [PISOS-1:0] MaskSube = {1'b0, {(PISOS-1){1'b1}}};
  localparam logic [PISOS-1:0] MaskBaja = {{(PISOS-1){1'b1}}, 1'b0};
  localparam logic [PISOS-1:0] Uno = {{(PISOS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StReposo, StMoviendo, StPuerta} estado_e;

  estado_e         estado_q;
  logic [TW-1:0]   timer_q;
  logic            llego_q;  // piso just advanced; stop decision due this cycle

  logic [PISOS-1:0] in_sube, in_baja, todas, sel;
  logic [PISOS-1:0] clr_sube, clr_baja, clr_cab;
  logic             arriba, abajo, aqui, adelante, hall_dir, parada, repique;
  logic [W-1:0]     piso_sig;

  always_comb begin
    in_sube  = llamada_sube & MaskSube;
    in_baja  = llamada_baja & MaskBaja;
    todas    = pend_sube | pend_baja | pend_cabina;
    sel      = Uno << piso;
    arriba   = 1'b0;
    abajo    = 1'b0;
    for (int i = 0; i < int'(PISOS); i++) begin
      if (i > int'(piso)) arriba = arriba | todas[i];
      if (i < int'(piso)) abajo  = abajo | todas[i];
    end
    aqui     = |(todas & sel);
    adelante = subiendo ? arriba : abajo;
    hall_dir = subiendo ? |(pend_sube & sel) : |(pend_baja & sel);
    parada   = |(pend_cabina & sel) | hall_dir | (!adelante && aqui) ||
               (piso == '0) || (piso == Tope);
    // A fresh same-direction or cab press at the open door keeps it open.
    repique  = |(llamada_cabina & sel) | (subiendo ? |(in_sube & sel) : |(in_baja & sel));
    if (subiendo) piso_sig = (piso == Tope) ? piso : piso + W'(1);
    else          piso_sig = (piso == '0) ? piso : piso - W'(1);

    clr_sube = '0;
    clr_baja = '0;
    clr_cab  = '0;
    unique case (estado_q)
      StReposo: begin
        if (aqui) begin
          clr_sube = sel;
          clr_baja = sel;
          clr_cab  = sel;
        end
      end
      StMoviendo: begin
        if (llego_q && parada && aqui) begin
          clr_cab = sel;
          if (subiendo || !adelante)  clr_sube = sel;
          if (!subiendo || !adelante) clr_baja = sel;
        end
      end
      StPuerta: begin
        clr_cab = sel;
        if (subiendo) clr_sube = sel;
        else          clr_baja = sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q       <= StReposo;
      timer_q        <= '0;
      llego_q        <= 1'b0;
      pend_sube      <= '0;
      pend_baja      <= '0;
      pend_cabina    <= '0;
      piso           <= '0;
      moviendo       <= 1'b0;
      subiendo       <= 1'b1;
      puerta_abierta <= 1'b0;
    end else begin
      // Clears only occur at the car floor with the door opening/open, so clear wins.
      pend_sube   <= (pend_sube | in_sube) & ~clr_sube;
      pend_baja   <= (pend_baja | in_baja) & ~clr_baja;
      pend_cabina <= (pend_cabina | llamada_cabina) & ~clr_cab;

      unique case (estado_q)
        StReposo: begin
          if (aqui) begin
            estado_q       <= StPuerta;
            puerta_abierta <= 1'b1;
            timer_q        <= Carga;
          end else if (arriba && (subiendo || !abajo)) begin
            estado_q <= StMoviendo;
            moviendo <= 1'b1;
            subiendo <= 1'b1;
            llego_q  <= 1'b0;
          end else if (abajo) begin
            estado_q <= StMoviendo;
            moviendo <= 1'b1;
            subiendo <= 1'b0;
            llego_q  <= 1'b0;
          end
        end
        StMoviendo: begin
          if (llego_q && parada) begin
            moviendo <= 1'b0;
            llego_q  <= 1'b0;
            if (aqui) begin
              estado_q       <= StPuerta;
              puerta_abierta <= 1'b1;
              timer_q        <= Carga;
            end else begin
              estado_q <= StReposo;
            end
          end else if (cambio_piso) begin
            piso    <= piso_sig;
            llego_q <= 1'b1;
          end else begin
            llego_q <= 1'b0;
          end
        end
        StPuerta: begin
          if (repique) begin
            timer_q <= Carga;
          end else if (timer_q == '0) begin
            estado_q       <= StReposo;
            puerta_abierta <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: estado_q <= StReposo;
      endcase
    end
  end

endmodule
